memory_access: RTL and testbench
================================

# memory_access

Memory stage of the five-stage Y86-64 pipeline, bundled with the M-to-W pipeline register. It sits directly downstream of the execute-to-memory register: it consumes the M-register fields, performs 8-byte data-memory reads and writes, and produces `m_valM_o`/`m_stat_o` for forwarding and PC selection. It registers the writeback-stage fields `W_*` that feed decode forwarding, register-file write, and `select_pc`.

## Interface
- `DMEM_BYTES`, default 1024: data memory size in bytes; legal byte addresses are 0..DMEM_BYTES-1.
- `clk_i  in  1`: clock; all state updates on the rising edge.
- `rst_n_i  in  1`: asynchronous, active-low reset of the W register.
- `W_stall_i  in  1`: hold the W register and suppress the memory write.
- `W_bubble_i  in  1`: load a nop into the W register.
- `M_stat_i  in  3`: M-stage status; 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `M_pc_i  in  64`: M-stage instruction PC.
- `M_icode_i  in  4`: M-stage icode.
- `M_valE_i  in  64`: ALU result; also the memory address for rmmovq, mrmovq, pushq and call.
- `M_valA_i  in  64`: store data; also the memory address for popq and ret.
- `M_dstE_i  in  4`: destination register for valE; 4'hF means none.
- `M_dstM_i  in  4`: destination register for valM; 4'hF means none.
- `m_valM_o  out  64`: combinational read data; 0 when no read or on error.
- `m_stat_o  out  3`: combinational stage status.
- `W_stat_o, W_pc_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o  out  3/64/4/64/64/4/4`: registered W fields.

## Operation
- Read instructions: mrmovq (5), popq (B), ret (9). Write instructions: rmmovq (4), pushq (A), call (8).
- Address selection:
  - popq and ret use `M_valA_i`.
  - rmmovq, mrmovq, pushq and call use `M_valE_i`.
- Every access is 8 bytes, little-endian, byte-addressed. Misaligned addresses are legal.
- Memory error condition: read or write instruction with `addr > DMEM_BYTES-8`. The comparison is done on the full 64-bit unsigned address, so a wrapped address such as 64'hFFFF_FFFF_FFFF_FFFC is an error.
- `m_stat_o` is 3 (ADR) on a memory error, otherwise `M_stat_i`.
- Read path: `m_valM_o` is the memory content at addr..addr+7, combinational (same cycle). It is 0 for non-read instructions and on error.
- Write path: memory bytes addr..addr+7 are written with `M_valA_i` on the rising edge. The write happens only if all of the following hold:
  - the instruction is a write instruction;
  - `M_stat_i`==1;
  - there is no memory error;
  - `W_stall_i`==0;
  - `rst_n_i`==1.
- Memory contents are not affected by reset. The array is zero-initialised at time 0.
- W register update on the rising edge, by priority:
  1. `W_stall_i`=1: all W fields hold (stall wins over bubble).
  2. `W_bubble_i`=1: load the nop value (stat 1, icode 4'h1, pc 0, valE 0, valM 0, dstE 4'hF, dstM 4'hF).
  3. Otherwise: load `m_stat_o`, `M_pc_i`, `M_icode_i`, `M_valE_i`, `m_valM_o`, `M_dstE_i`, `M_dstM_i`.
- If a memory error occurs, `W_dstE_o` and `W_dstM_o` are still loaded unchanged. Writeback suppression on non-AOK status belongs to the register file.

## Timing
- Reset (`rst_n_i` low, asynchronous) forces the W register to the nop value immediately. The nop value is: `W_stat_o`=1, `W_icode_o`=1, `W_pc_o`=0, `W_valE_o`=0, `W_valM_o`=0, `W_dstE_o`=4'hF, `W_dstM_o`=4'hF.
- A W-register load happens on the first rising edge after reset deassertion.
- Reset asserted during a write cycle: the write is dropped and memory is unchanged.
- `m_valM_o` and `m_stat_o` have zero-cycle latency from the M inputs and from memory contents. W outputs have one-cycle latency.
- Read-after-write to the same address: a write on edge N is visible on `m_valM_o` in cycle N+1. There is no same-cycle bypass, because the pipeline never places a read and a write in M together.
- Overlapping partial addresses (for example a write at 8 and a read at 12) must return the merged bytes.

## Test plan
- rmmovq stores 64'h0123_4567_89AB_CDEF at valE=16, then mrmovq reads valE=16 with dstM=3.
  - Required: `m_valM_o`=64'h0123_4567_89AB_CDEF in the cycle of the mrmovq.
  - Required: after the next edge, `W_valM_o`=64'h0123_4567_89AB_CDEF, `W_dstM_o`=3, `W_stat_o`=1.
- pushq writes 64'h55 at valE=1016, popq reads with valA=1016, then mrmovq reads at valE=12.
  - Required: the popq gives `m_valM_o`=64'h55.
  - Required: a misaligned read at 12 returns the bytes previously written at 16..19 in its upper half.
- rmmovq at valE=1017 with DMEM_BYTES=1024.
  - Required: `m_stat_o`=3 and no memory change (a read of 1016 is unchanged).
  - Required: valE=1016 is accepted.
  - Required: valE=64'hFFFF_FFFF_FFFF_FFF8 gives ADR.
- Write instruction with `W_stall_i`=1 for 2 cycles.
  - Required: W fields held and memory unchanged.
  - Required: after release, the write occurs on that edge.
- `W_bubble_i`=1 and `W_stall_i`=1 together, then `W_bubble_i` alone.
  - Required: first hold, then the nop value (icode 1, dstE/dstM 4'hF).
- Assert `rst_n_i` mid-clock-phase while a write is pending.
  - Required: W outputs go to the nop value immediately (before any edge).
  - Required: the target address is not written.
  - Required: previously written data survives reset.

Source files
------------

// File: rtl/memory_access_if.sv
// Memory-stage bus: M-register fields and W control in,
// combinational m_* results and registered W fields out.
interface memory_access_if;
  logic        W_stall_i;
  logic        W_bubble_i;
  logic [2:0]  M_stat_i;
  logic [63:0] M_pc_i;
  logic [3:0]  M_icode_i;
  logic [63:0] M_valE_i;
  logic [63:0] M_valA_i;
  logic [3:0]  M_dstE_i;
  logic [3:0]  M_dstM_i;
  logic [63:0] m_valM_o;
  logic [2:0]  m_stat_o;
  logic [2:0]  W_stat_o;
  logic [63:0] W_pc_o;
  logic [3:0]  W_icode_o;
  logic [63:0] W_valE_o;
  logic [63:0] W_valM_o;
  logic [3:0]  W_dstE_o;
  logic [3:0]  W_dstM_o;

  modport master (
    output W_stall_i, W_bubble_i,
    output M_stat_i, M_pc_i, M_icode_i,
    output M_valE_i, M_valA_i,
    output M_dstE_i, M_dstM_i,
    input  m_valM_o, m_stat_o,
    input  W_stat_o, W_pc_o, W_icode_o,
    input  W_valE_o, W_valM_o,
    input  W_dstE_o, W_dstM_o
  );

  modport slave (
    input  W_stall_i, W_bubble_i,
    input  M_stat_i, M_pc_i, M_icode_i,
    input  M_valE_i, M_valA_i,
    input  M_dstE_i, M_dstM_i,
    output m_valM_o, m_stat_o,
    output W_stat_o, W_pc_o, W_icode_o,
    output W_valE_o, W_valM_o,
    output W_dstE_o, W_dstM_o
  );
endinterface

// File: rtl/memory_access.sv
// Y86-64 memory stage: 8-byte LE data memory access
// plus the M-to-W pipeline register.
module memory_access #(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  memory_access_if.slave bus
);
  localparam int unsigned AW = $clog2(DMEM_BYTES);
  localparam logic [63:0] LAST = 64'(DMEM_BYTES - 8);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_ADR = 3'd3;

  typedef struct packed {
    logic [2:0]  stat;
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_t;

  localparam w_t W_NOP = '{
    stat: S_AOK, pc: 64'd0, icode: 4'h1,
    valE: 64'd0, valM: 64'd0,
    dstE: 4'hF, dstM: 4'hF
  };

  logic [7:0]    mem_q [DMEM_BYTES];
  logic          is_rd;
  logic          is_wr;
  logic          err;
  logic          wr_en;
  logic [63:0]   addr;
  logic [63:0]   rd_data;
  logic [AW-1:0] base;
  w_t            w_q;
  w_t            w_d;

  // Classify the M-stage instruction as read or write
  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    unique case (bus.M_icode_i)
      I_MRMOVQ, I_POPQ, I_RET:   is_rd = 1'b1;
      I_RMMOVQ, I_PUSHQ, I_CALL: is_wr = 1'b1;
      default: ;
    endcase
  end

  // Stack pops address through valA; all else through valE
  assign addr = (bus.M_icode_i == I_POPQ ||
                 bus.M_icode_i == I_RET)
              ? bus.M_valA_i : bus.M_valE_i;

  // Full 64-bit compare so wrapped addresses fault too
  assign err  = (is_rd | is_wr) && (addr > LAST);
  assign base = addr[AW-1:0];

  // Gather eight little-endian bytes starting at base
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++)
      rd_data[8*i +: 8] = mem_q[base + AW'(i)];
  end

  assign bus.m_valM_o = (is_rd && !err) ? rd_data : 64'd0;
  assign bus.m_stat_o = err ? S_ADR : bus.M_stat_i;

  assign wr_en = is_wr && (bus.M_stat_i == S_AOK) && !err
              && !bus.W_stall_i && rst_n_i;

  // Data memory store; contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en)
      for (int i = 0; i < 8; i++)
        mem_q[base + AW'(i)] <= bus.M_valA_i[8*i +: 8];
  end

  // Next W value: stall holds, bubble inserts a nop
  always_comb begin
    w_d = w_q;
    if (bus.W_stall_i)
      w_d = w_q;
    else if (bus.W_bubble_i)
      w_d = W_NOP;
    else
      w_d = '{
        stat:  bus.m_stat_o,
        pc:    bus.M_pc_i,
        icode: bus.M_icode_i,
        valE:  bus.M_valE_i,
        valM:  bus.m_valM_o,
        dstE:  bus.M_dstE_i,
        dstM:  bus.M_dstM_i
      };
  end

  // W pipeline register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      w_q <= W_NOP;
    else
      w_q <= w_d;
  end

  assign bus.W_stat_o  = w_q.stat;
  assign bus.W_pc_o    = w_q.pc;
  assign bus.W_icode_o = w_q.icode;
  assign bus.W_valE_o  = w_q.valE;
  assign bus.W_valM_o  = w_q.valM;
  assign bus.W_dstE_o  = w_q.dstE;
  assign bus.W_dstM_o  = w_q.dstM;
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: byte-array reference model,
// directed scenarios plus a randomized instruction mix.
module tb_memory_access;
  localparam int unsigned MB = 1024;

  typedef struct packed {
    logic [2:0]  stat;
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_t;

  localparam w_t NOP = '{
    stat: 3'd1, pc: 64'd0, icode: 4'h1,
    valE: 64'd0, valM: 64'd0,
    dstE: 4'hF, dstM: 4'hF
  };

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  memory_access_if bus();

  memory_access #(.DMEM_BYTES(MB)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  logic [7:0]  mm [MB];
  w_t          ew;
  logic [63:0] exp_valM;
  logic [2:0]  exp_stat;
  logic [63:0] p_addr;
  logic        p_err;
  logic        p_wr;
  int          vec = 0;
  int          miss = 0;

  function automatic w_t w_act();
    return '{bus.W_stat_o, bus.W_pc_o, bus.W_icode_o,
             bus.W_valE_o, bus.W_valM_o,
             bus.W_dstE_o, bus.W_dstM_o};
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic predict();
    logic rd, wr;
    rd = bus.M_icode_i inside {4'h5, 4'h9, 4'hB};
    wr = bus.M_icode_i inside {4'h4, 4'hA, 4'h8};
    p_addr = (bus.M_icode_i inside {4'h9, 4'hB})
           ? bus.M_valA_i : bus.M_valE_i;
    p_err = (rd || wr) && (p_addr > 64'(MB - 8));
    p_wr = wr;
    exp_stat = p_err ? 3'd3 : bus.M_stat_i;
    exp_valM = '0;
    if (rd && !p_err)
      for (int i = 0; i < 8; i++)
        exp_valM[8*i +: 8] = mm[int'(p_addr) + i];
  endtask

  task automatic drive(
    input logic [2:0]  st,
    input logic [63:0] pc,
    input logic [3:0]  ic,
    input logic [63:0] ve,
    input logic [63:0] va,
    input logic [3:0]  de,
    input logic [3:0]  dm,
    input logic        stall,
    input logic        bub
  );
    bus.M_stat_i   = st;
    bus.M_pc_i     = pc;
    bus.M_icode_i  = ic;
    bus.M_valE_i   = ve;
    bus.M_valA_i   = va;
    bus.M_dstE_i   = de;
    bus.M_dstM_i   = dm;
    bus.W_stall_i  = stall;
    bus.W_bubble_i = bub;
    #1;
    predict();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (p_wr && bus.M_stat_i == 3'd1 && !p_err && !bus.W_stall_i)
        for (int i = 0; i < 8; i++)
          mm[int'(p_addr) + i] = bus.M_valA_i[8*i +: 8];
      if (!bus.W_stall_i)
        ew = bus.W_bubble_i ? NOP : '{
          stat: exp_stat, pc: bus.M_pc_i,
          icode: bus.M_icode_i, valE: bus.M_valE_i,
          valM: exp_valM, dstE: bus.M_dstE_i,
          dstM: bus.M_dstM_i};
    end else begin
      ew = NOP;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(3'd1, 64'h40, 4'h1, 64'd0, 64'd0,
          4'hF, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    vec++;
    if (w_act() !== NOP) begin
      miss++;
      $display("FAIL reset_nop act=%h exp=%h", w_act(), NOP);
    end
    tick();
    vec++;
    if (w_act() !== NOP) begin
      miss++;
      $display("FAIL reset_hold act=%h exp=%h", w_act(), NOP);
    end
    #2 rst_n = 1'b1;
    ew = NOP;
  endtask

  task automatic test_init_mem();
    for (int a = 0; a < int'(MB); a += 8) begin
      drive(3'd1, 64'(a), 4'h4, 64'(a), r64(),
            4'hF, 4'hF, 1'b0, 1'b0);
      vec++;
      if (bus.m_stat_o !== 3'd1) begin
        miss++;
        $display("FAIL init_stat a=%0d act=%0d exp=1",
                 a, bus.m_stat_o);
      end
      tick();
      if (a == 0) begin
        vec++;
        if (w_act() !== ew) begin
          miss++;
          $display("FAIL first_load act=%h exp=%h", w_act(), ew);
        end
      end
    end
  endtask

  task automatic test_store_load();
    drive(3'd1, 64'h100, 4'h4, 64'd16, 64'h0123_4567_89AB_CDEF,
          4'hF, 4'hF, 1'b0, 1'b0);
    tick();
    drive(3'd1, 64'h10A, 4'h5, 64'd16, 64'd0,
          4'hF, 4'd3, 1'b0, 1'b0);
    vec++;
    if (bus.m_valM_o !== 64'h0123_4567_89AB_CDEF) begin
      miss++;
      $display("FAIL load16 act=%h exp=%h",
               bus.m_valM_o, 64'h0123_4567_89AB_CDEF);
    end
    tick();
    vec++;
    if (bus.W_valM_o !== 64'h0123_4567_89AB_CDEF ||
        bus.W_dstM_o !== 4'd3 || bus.W_stat_o !== 3'd1) begin
      miss++;
      $display("FAIL w_load16 act=%h/%0d/%0d exp=%h/3/1",
               bus.W_valM_o, bus.W_dstM_o, bus.W_stat_o,
               64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_push_pop();
    drive(3'd1, 64'h200, 4'hA, 64'd1016, 64'h55,
          4'd4, 4'hF, 1'b0, 1'b0);
    tick();
    drive(3'd1, 64'h202, 4'hB, 64'd1024, 64'd1016,
          4'd4, 4'd2, 1'b0, 1'b0);
    vec++;
    if (bus.m_valM_o !== 64'h55) begin
      miss++;
      $display("FAIL popq act=%h exp=%h", bus.m_valM_o, 64'h55);
    end
    tick();
    drive(3'd1, 64'h204, 4'h5, 64'd12, 64'd0,
          4'hF, 4'd1, 1'b0, 1'b0);
    vec++;
    if (bus.m_valM_o[63:32] !== 32'h89AB_CDEF ||
        bus.m_valM_o !== exp_valM) begin
      miss++;
      $display("FAIL misalign12 act=%h exp=%h",
               bus.m_valM_o, exp_valM);
    end
    tick();
  endtask

  task automatic test_bounds();
    logic [63:0] v;
    drive(3'd1, 64'h300, 4'h4, 64'd1017, 64'hDEAD_BEEF,
          4'hF, 4'hF, 1'b0, 1'b0);
    vec++;
    if (bus.m_stat_o !== 3'd3) begin
      miss++;
      $display("FAIL adr1017 act=%0d exp=3", bus.m_stat_o);
    end
    tick();
    vec++;
    if (w_act() !== ew) begin
      miss++;
      $display("FAIL w_adr act=%h exp=%h", w_act(), ew);
    end
    drive(3'd1, 64'h30A, 4'h5, 64'd1016, 64'd0,
          4'hF, 4'd1, 1'b0, 1'b0);
    vec++;
    if (bus.m_valM_o !== 64'h55) begin
      miss++;
      $display("FAIL adr_nowrite act=%h exp=%h",
               bus.m_valM_o, 64'h55);
    end
    tick();
    v = r64();
    drive(3'd1, 64'h314, 4'h4, 64'd1016, v,
          4'hF, 4'hF, 1'b0, 1'b0);
    vec++;
    if (bus.m_stat_o !== 3'd1) begin
      miss++;
      $display("FAIL ok1016 act=%0d exp=1", bus.m_stat_o);
    end
    tick();
    drive(3'd1, 64'h31E, 4'h5, 64'd1016, 64'd0,
          4'hF, 4'd1, 1'b0, 1'b0);
    vec++;
    if (bus.m_valM_o !== v) begin
      miss++;
      $display("FAIL rd1016 act=%h exp=%h", bus.m_valM_o, v);
    end
    tick();
    drive(3'd1, 64'h328, 4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'd7,
          4'hF, 4'hF, 1'b0, 1'b0);
    vec++;
    if (bus.m_stat_o !== 3'd3) begin
      miss++;
      $display("FAIL adr_wrap act=%0d exp=3", bus.m_stat_o);
    end
    tick();
    drive(3'd1, 64'h332, 4'h9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC,
          4'd4, 4'hF, 1'b0, 1'b0);
    vec++;
    if (bus.m_stat_o !== 3'd3 || bus.m_valM_o !== 64'd0) begin
      miss++;
      $display("FAIL ret_wrap act=%0d/%h exp=3/0",
               bus.m_stat_o, bus.m_valM_o);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [63:0] old;
    logic [63:0] v;
    w_t          held;
    old = {mm[407], mm[406], mm[405], mm[404],
           mm[403], mm[402], mm[401], mm[400]};
    v = ~old;
    held = ew;
    drive(3'd1, 64'h400, 4'h4, 64'd400, v,
          4'hF, 4'hF, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      vec++;
      if (w_act() !== held) begin
        miss++;
        $display("FAIL stall_hold c=%0d act=%h exp=%h",
                 c, w_act(), held);
      end
    end
    drive(3'd1, 64'h40A, 4'h5, 64'd400, 64'd0,
          4'hF, 4'd5, 1'b1, 1'b0);
    vec++;
    if (bus.m_valM_o !== old) begin
      miss++;
      $display("FAIL stall_nowrite act=%h exp=%h",
               bus.m_valM_o, old);
    end
    drive(3'd1, 64'h400, 4'h4, 64'd400, v,
          4'hF, 4'hF, 1'b0, 1'b0);
    tick();
    drive(3'd1, 64'h40A, 4'h5, 64'd400, 64'd0,
          4'hF, 4'd5, 1'b0, 1'b0);
    vec++;
    if (bus.m_valM_o !== v) begin
      miss++;
      $display("FAIL stall_release act=%h exp=%h",
               bus.m_valM_o, v);
    end
    tick();
  endtask

  task automatic test_stall_bubble();
    w_t held;
    held = ew;
    drive(3'd1, 64'h500, 4'h6, 64'd9, 64'd3,
          4'd2, 4'hF, 1'b1, 1'b1);
    tick();
    vec++;
    if (w_act() !== held) begin
      miss++;
      $display("FAIL stall_over_bubble act=%h exp=%h",
               w_act(), held);
    end
    drive(3'd1, 64'h500, 4'h6, 64'd9, 64'd3,
          4'd2, 4'hF, 1'b0, 1'b1);
    tick();
    vec++;
    if (w_act() !== NOP || bus.W_icode_o !== 4'h1 ||
        bus.W_dstE_o !== 4'hF || bus.W_dstM_o !== 4'hF) begin
      miss++;
      $display("FAIL bubble_nop act=%h exp=%h", w_act(), NOP);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] old;
    old = {mm[607], mm[606], mm[605], mm[604],
           mm[603], mm[602], mm[601], mm[600]};
    drive(3'd1, 64'h600, 4'h4, 64'd600, ~old,
          4'hF, 4'hF, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (w_act() !== NOP) begin
      miss++;
      $display("FAIL rst_async act=%h exp=%h", w_act(), NOP);
    end
    tick();
    #2 rst_n = 1'b1;
    drive(3'd1, 64'h60A, 4'h5, 64'd600, 64'd0,
          4'hF, 4'd1, 1'b0, 1'b0);
    vec++;
    if (bus.m_valM_o !== old) begin
      miss++;
      $display("FAIL rst_dropwrite act=%h exp=%h",
               bus.m_valM_o, old);
    end
    tick();
    drive(3'd1, 64'h614, 4'h5, 64'd16, 64'd0,
          4'hF, 4'd1, 1'b0, 1'b0);
    vec++;
    if (bus.m_valM_o !== 64'h0123_4567_89AB_CDEF) begin
      miss++;
      $display("FAIL rst_survive act=%h exp=%h",
               bus.m_valM_o, 64'h0123_4567_89AB_CDEF);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  ic;
    logic [2:0]  st;
    logic [63:0] a;
    logic [63:0] va;
    for (int n = 0; n < 250; n++) begin
      ic = 4'($urandom_range(0, 11));
      st = ($urandom_range(0, 3) != 0) ? 3'd1
         : 3'($urandom_range(2, 4));
      a = ($urandom_range(0, 9) != 0)
        ? 64'($urandom_range(0, MB - 1)) : r64();
      va = (ic == 4'h9 || ic == 4'hB) ? a : r64();
      drive(st, r64(), ic, (ic == 4'h9 || ic == 4'hB) ? r64() : a,
            va, 4'($urandom), 4'($urandom),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0);
      vec++;
      if (bus.m_valM_o !== exp_valM ||
          bus.m_stat_o !== exp_stat) begin
        miss++;
        $display("FAIL rnd_comb n=%0d act=%h/%0d exp=%h/%0d",
                 n, bus.m_valM_o, bus.m_stat_o,
                 exp_valM, exp_stat);
      end
      tick();
      vec++;
      if (w_act() !== ew) begin
        miss++;
        $display("FAIL rnd_w n=%0d act=%h exp=%h",
                 n, w_act(), ew);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_mem();
    test_store_load();
    test_push_pop();
    test_bounds();
    test_stall();
    test_stall_bubble();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end
endmodule
